// File: rtl/mips_mc_control_unit.sv
// ---------------------------------------------------------------------------
// mips_mc_control_unit
//
// Main control FSM for the multi-cycle MIPS core. The FSM reads Op and Funct
// from the instruction register. It steps the datapath control strobes
// through fetch, decode, execute, memory and write-back. This is a Moore
// machine: the outputs depend only on the current state. The one exception
// is ALUControl in RTYPE_EX, which is also decoded from Funct.
//
// Ports
//   clk        core clock, rising-edge
//   reset      synchronous, active-low
//   Op         IR[31:26]
//   Funct      IR[5:0]
//   IorD       memory address select (0 = PC, 1 = ALUOut)
//   MemWrite   memory write enable
//   IRWrite    instruction register load
//   PCWrite    unconditional PC load
//   BranchEq   PC load if ALU Zero
//   BranchNeq  PC load if ALU not Zero
//   PCSrc      PC source (0 = ALU result, 1 = ALUOut)
//   ALUSrcA    ALU A (0 = PC, 1 = reg A)
//   RegWrite   register file write enable
//   MemtoReg   write-back data (0 = ALUOut, 1 = MDR)
//   RegDst     destination (0 = rt, 1 = rd)
//   ALUSrcB    ALU B (00 = B, 01 = 4, 10 = imm, 11 = imm << 2)
//   ALUControl ALU operation
//   state_o    current state, for debug only
// ---------------------------------------------------------------------------
module mips_mc_control_unit #(
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [5:0]         Op,
   input  logic [5:0]         Funct,
   output logic               IorD,
   output logic               MemWrite,
   output logic               IRWrite,
   output logic               PCWrite,
   output logic               BranchEq,
   output logic               BranchNeq,
   output logic               PCSrc,
   output logic               ALUSrcA,
   output logic               RegWrite,
   output logic               MemtoReg,
   output logic               RegDst,
   output logic [1:0]         ALUSrcB,
   output logic [3:0]         ALUControl,
   output logic [STATE_W-1:0] state_o
);

   typedef enum logic [STATE_W-1:0] {
      IDLE     = STATE_W'(0),
      FETCH    = STATE_W'(1),
      DECODE   = STATE_W'(2),
      MEMADR   = STATE_W'(3),
      MEMRD    = STATE_W'(4),
      MEMWB    = STATE_W'(5),
      MEMWR    = STATE_W'(6),
      RTYPE_EX = STATE_W'(7),
      RTYPE_WB = STATE_W'(8),
      ADDI_EX  = STATE_W'(9),
      ADDI_WB  = STATE_W'(10),
      BEQ      = STATE_W'(11),
      BNE      = STATE_W'(12)
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;
   localparam logic [5:0] FN_NOR = 6'b100111;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;

   state_t state_reg;
   state_t state_next;

   logic       funct_legal;
   logic [3:0] funct_alu;

   // Funct decode. DECODE uses it to reject unknown R-type functions early.
   // RTYPE_EX uses it to select the ALU operation.
   always_comb begin
      funct_legal = 1'b1;
      funct_alu   = ALU_AND;
      case (Funct)
         FN_ADD:  funct_alu = ALU_ADD;
         FN_SUB:  funct_alu = ALU_SUB;
         FN_AND:  funct_alu = ALU_AND;
         FN_OR:   funct_alu = ALU_OR;
         FN_SLT:  funct_alu = ALU_SLT;
         FN_NOR:  funct_alu = ALU_NOR;
         default: funct_legal = 1'b0;
      endcase
   end

   // State register. Dropping reset mid-instruction sends the machine
   // straight to IDLE. Any pending store or write-back is never issued.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = FETCH;
      case (state_reg)
         IDLE:     state_next = FETCH;
         FETCH:    state_next = DECODE;
         DECODE: begin
            case (Op)
               OP_RTYPE:     state_next = funct_legal ? RTYPE_EX : FETCH;
               OP_LW, OP_SW: state_next = MEMADR;
               OP_ADDI:      state_next = ADDI_EX;
               OP_BEQ:       state_next = BEQ;
               OP_BNE:       state_next = BNE;
               default:      state_next = FETCH;   // unknown op runs as a nop
            endcase
         end
         MEMADR:   state_next = (Op == OP_LW) ? MEMRD : MEMWR;
         MEMRD:    state_next = MEMWB;
         MEMWB:    state_next = FETCH;
         MEMWR:    state_next = FETCH;
         RTYPE_EX: state_next = RTYPE_WB;
         RTYPE_WB: state_next = FETCH;
         ADDI_EX:  state_next = ADDI_WB;
         ADDI_WB:  state_next = FETCH;
         BEQ:      state_next = FETCH;
         BNE:      state_next = FETCH;
         default:  state_next = FETCH;           // recover from stray encodings
      endcase
   end

   // Output decode. Every strobe defaults to 0. Each state raises only the
   // strobes it needs.
   always_comb begin
      IorD       = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      BranchEq   = 1'b0;
      BranchNeq  = 1'b0;
      PCSrc      = 1'b0;
      ALUSrcA    = 1'b0;
      RegWrite   = 1'b0;
      MemtoReg   = 1'b0;
      RegDst     = 1'b0;
      ALUSrcB    = 2'b00;
      ALUControl = ALU_AND;
      case (state_reg)
         FETCH: begin
            IRWrite    = 1'b1;
            PCWrite    = 1'b1;
            ALUSrcB    = 2'b01;
            ALUControl = ALU_ADD;       // PC + 4
         end
         DECODE: begin
            ALUSrcB    = 2'b11;
            ALUControl = ALU_ADD;       // branch target parked in ALUOut
         end
         MEMADR: begin
            ALUSrcA    = 1'b1;
            ALUSrcB    = 2'b10;
            ALUControl = ALU_ADD;
         end
         MEMRD: begin
            IorD = 1'b1;
         end
         MEMWB: begin
            MemtoReg = 1'b1;
            RegWrite = 1'b1;
         end
         MEMWR: begin
            IorD     = 1'b1;
            MemWrite = 1'b1;
         end
         RTYPE_EX: begin
            ALUSrcA    = 1'b1;
            ALUControl = funct_alu;
         end
         RTYPE_WB: begin
            RegDst   = 1'b1;
            RegWrite = 1'b1;
         end
         ADDI_EX: begin
            ALUSrcA    = 1'b1;
            ALUSrcB    = 2'b10;
            ALUControl = ALU_ADD;
         end
         ADDI_WB: begin
            RegWrite = 1'b1;
         end
         BEQ: begin
            ALUSrcA    = 1'b1;
            ALUControl = ALU_SUB;
            PCSrc      = 1'b1;
            BranchEq   = 1'b1;
         end
         BNE: begin
            ALUSrcA    = 1'b1;
            ALUControl = ALU_SUB;
            PCSrc      = 1'b1;
            BranchNeq  = 1'b1;
         end
         default: ;                     // IDLE and stray encodings: all 0
      endcase
   end

   assign state_o = state_reg;

endmodule

// File: tb/tb_mips_mc_control_unit.sv
module tb_mips_mc_control_unit;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] Op;
   logic [5:0] Funct;
   logic       IorD, MemWrite, IRWrite, PCWrite, BranchEq, BranchNeq, PCSrc;
   logic       ALUSrcA, RegWrite, MemtoReg, RegDst;
   logic [1:0] ALUSrcB;
   logic [3:0] ALUControl;
   logic [3:0] state_o;

   mips_mc_control_unit #(.STATE_W(4)) dut (
      .clk(clk), .reset(reset), .Op(Op), .Funct(Funct),
      .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
      .BranchEq(BranchEq), .BranchNeq(BranchNeq), .PCSrc(PCSrc),
      .ALUSrcA(ALUSrcA), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
      .RegDst(RegDst), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
      .state_o(state_o)
   );

   always #5 clk = ~clk;

   // One observed cycle: state plus every control output
   typedef struct packed {
      logic [3:0] st;
      logic       iord, memw, irw, pcw, beq, bne, pcsrc, srca, regw, m2r, rdst;
      logic [1:0] srcb;
      logic [3:0] aluc;
   } ctrl_t;

   typedef struct {
      string      name;
      logic [5:0] op;
      logic [5:0] funct;
      int         len;     // cycles, FETCH inclusive
      logic [23:0] seq;    // state of cycle k in seq[4k +: 4]
   } vec_t;

   int    checks   = 0;
   int    failures = 0;
   ctrl_t exp_q[$];
   logic [23:0] rec_seq;
   int    rec_len;

   function automatic ctrl_t sample();
      ctrl_t g;
      g.st = state_o; g.iord = IorD; g.memw = MemWrite; g.irw = IRWrite;
      g.pcw = PCWrite; g.beq = BranchEq; g.bne = BranchNeq; g.pcsrc = PCSrc;
      g.srca = ALUSrcA; g.regw = RegWrite; g.m2r = MemtoReg; g.rdst = RegDst;
      g.srcb = ALUSrcB; g.aluc = ALUControl;
      return g;
   endfunction

   task automatic check(input string tag, input ctrl_t e);
      ctrl_t g;
      g = sample();
      checks++;
      if (g !== e) begin
         failures++;
         $display("FAIL %s: got st=%0d ctrl=%h, want st=%0d ctrl=%h",
                  tag, g.st, g, e.st, e);
      end
   endtask

   // Reference model: builds the expected cycle-by-cycle trace of one
   // instruction from its class (timeline of phases and the strobes each raises)
   task automatic rtype_alu(input logic [5:0] f, output bit legal, output logic [3:0] code);
      legal = 1'b1;
      code  = 4'b0000;
      case (f)
         6'b100000: code = 4'b0010;
         6'b100010: code = 4'b0110;
         6'b100100: code = 4'b0000;
         6'b100101: code = 4'b0001;
         6'b101010: code = 4'b0111;
         6'b100111: code = 4'b1100;
         default:   legal = 1'b0;
      endcase
   endtask

   task automatic build(input logic [5:0] op, input logic [5:0] funct);
      ctrl_t c;
      bit legal;
      logic [3:0] code;
      exp_q.delete();
      c = '0; c.st = 4'd1; c.irw = 1; c.pcw = 1; c.srcb = 2'b01; c.aluc = 4'b0010;
      exp_q.push_back(c);
      c = '0; c.st = 4'd2; c.srcb = 2'b11; c.aluc = 4'b0010;
      exp_q.push_back(c);
      case (op)
         6'b000000: begin
            rtype_alu(funct, legal, code);
            if (legal) begin
               c = '0; c.st = 4'd7; c.srca = 1; c.aluc = code; exp_q.push_back(c);
               c = '0; c.st = 4'd8; c.rdst = 1; c.regw = 1;    exp_q.push_back(c);
            end
         end
         6'b100011, 6'b101011: begin
            c = '0; c.st = 4'd3; c.srca = 1; c.srcb = 2'b10; c.aluc = 4'b0010;
            exp_q.push_back(c);
            if (op == 6'b100011) begin
               c = '0; c.st = 4'd4; c.iord = 1;            exp_q.push_back(c);
               c = '0; c.st = 4'd5; c.m2r = 1; c.regw = 1; exp_q.push_back(c);
            end else begin
               c = '0; c.st = 4'd6; c.iord = 1; c.memw = 1; exp_q.push_back(c);
            end
         end
         6'b001000: begin
            c = '0; c.st = 4'd9; c.srca = 1; c.srcb = 2'b10; c.aluc = 4'b0010;
            exp_q.push_back(c);
            c = '0; c.st = 4'd10; c.regw = 1; exp_q.push_back(c);
         end
         6'b000100, 6'b000101: begin
            c = '0; c.srca = 1; c.aluc = 4'b0110; c.pcsrc = 1;
            if (op == 6'b000100) begin c.st = 4'd11; c.beq = 1; end
            else                 begin c.st = 4'd12; c.bne = 1; end
            exp_q.push_back(c);
         end
         default: ;
      endcase
   endtask

   // Called at a negedge with the DUT in FETCH; returns at the negedge where
   // the next FETCH is visible. abort_at >= 0 drops reset after that cycle.
   task automatic run_instr(input string tag, input logic [5:0] op,
                            input logic [5:0] funct, input int abort_at);
      Op = op;
      Funct = funct;
      build(op, funct);
      rec_seq = '0;
      rec_len = 0;
      for (int i = 0; i < exp_q.size(); i++) begin
         check(tag, exp_q[i]);
         rec_seq[4*i +: 4] = state_o;
         rec_len++;
         if (i == abort_at) begin
            reset = 1'b0;
            @(negedge clk);
            check({tag, "_rst"}, ctrl_t'(0));
            reset = 1'b1;
            @(negedge clk);
            return;
         end
         @(negedge clk);
      end
   endtask

   vec_t vecs[11];
   ctrl_t fetch_exp;
   logic [5:0] ops[7];
   logic [5:0] fns[6];

   initial begin
      vecs[0]  = '{"addi", 6'b001000, 6'b000000, 4, 24'h00A921};
      vecs[1]  = '{"add",  6'b000000, 6'b100000, 4, 24'h008721};
      vecs[2]  = '{"sub",  6'b000000, 6'b100010, 4, 24'h008721};
      vecs[3]  = '{"slt",  6'b000000, 6'b101010, 4, 24'h008721};
      vecs[4]  = '{"rbad", 6'b000000, 6'b000000, 2, 24'h000021};
      vecs[5]  = '{"lw",   6'b100011, 6'b010101, 5, 24'h054321};
      vecs[6]  = '{"sw",   6'b101011, 6'b000000, 4, 24'h006321};
      vecs[7]  = '{"beq",  6'b000100, 6'b000000, 3, 24'h000B21};
      vecs[8]  = '{"bne",  6'b000101, 6'b000000, 3, 24'h000C21};
      vecs[9]  = '{"nop",  6'b111111, 6'b100000, 2, 24'h000021};
      vecs[10] = '{"nor",  6'b000000, 6'b100111, 4, 24'h008721};
      ops = '{6'b000000, 6'b100011, 6'b101011, 6'b001000, 6'b000100, 6'b000101, 6'b111111};
      fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};

      fetch_exp = '0;
      fetch_exp.st = 4'd1; fetch_exp.irw = 1; fetch_exp.pcw = 1;
      fetch_exp.srcb = 2'b01; fetch_exp.aluc = 4'b0010;

      // Reset held low for two edges, then released
      reset = 1'b0;
      Op = '0;
      Funct = '0;
      @(negedge clk);
      check("reset1", ctrl_t'(0));
      @(negedge clk);
      check("reset2", ctrl_t'(0));
      reset = 1'b1;
      @(negedge clk);
      check("release_fetch", fetch_exp);

      // Directed table: state sequences and cycle counts
      foreach (vecs[k]) begin
         run_instr(vecs[k].name, vecs[k].op, vecs[k].funct, -1);
         checks++;
         if (rec_len != vecs[k].len || rec_seq != vecs[k].seq) begin
            failures++;
            $display("FAIL seq_%s: got len=%0d seq=%h, want len=%0d seq=%h",
                     vecs[k].name, rec_len, rec_seq, vecs[k].len, vecs[k].seq);
         end
      end
      check("after_table", fetch_exp);

      // Reset dropped at the edge that would enter MEMRD or MEMWR
      run_instr("lw_abort", 6'b100011, 6'b000000, 2);
      check("lw_abort_fetch", fetch_exp);
      run_instr("sw_abort", 6'b101011, 6'b000000, 2);
      check("sw_abort_fetch", fetch_exp);
      run_instr("rtype_abort_ex", 6'b000000, 6'b100101, 2);
      check("rt_abort_fetch", fetch_exp);

      // Randomized instruction stream with occasional reset aborts
      for (int n = 0; n < 400; n++) begin
         logic [5:0] op, fn;
         int ab;
         op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 6)];
         fn = ($urandom_range(0, 4) == 0) ? 6'($urandom) : fns[$urandom_range(0, 5)];
         ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4)) : -1;
         run_instr("rand", op, fn, ab);
      end
      check("final_fetch", fetch_exp);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
